// File: rtl/dense_engine.sv
// Sequential fully-connected layer: one multiply-accumulate per cycle against an external weight memory,
// followed by a Q-format rescale, saturation and a selectable activation. Define DENSE_ENGINE_BIAS_EN for per-neuron bias words.
module dense_engine #(
  parameter int IN_SIZE   = 42,
  parameter int OUT_SIZE  = 24,
  parameter int DATA_W    = 16,
  parameter int WEIGHT_W  = 16,
  parameter int FRAC_BITS = 8,
`ifdef DENSE_ENGINE_BIAS_EN
  localparam int STRIDE   = IN_SIZE + 1,
`else
  localparam int STRIDE   = IN_SIZE,
`endif
  localparam int AW       = (OUT_SIZE * STRIDE > 1) ? $clog2(OUT_SIZE * STRIDE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   act_mode,
  input  logic [IN_SIZE*DATA_W-1:0]    in_data,
  output logic [AW-1:0]                w_addr,
  input  logic [WEIGHT_W-1:0]          w_rdata,
  output logic                         busy,
  output logic                         done,
  output logic [OUT_SIZE*DATA_W-1:0]   out_data
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int ACC_W  = DATA_W + WEIGHT_W + $clog2(IN_SIZE + 1) + 1;
  localparam int JW     = $clog2(STRIDE + 1);
  localparam int NW     = $clog2(OUT_SIZE + 1);

  localparam logic signed [DATA_W-1:0] D_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ONE_Q     = DATA_W'(2 ** FRAC_BITS);
  localparam logic signed [DATA_W-1:0] NEG_ONE_Q = -ONE_Q;
  localparam logic signed [DATA_W:0]   ONE_X     = (DATA_W+1)'(2 ** FRAC_BITS);
  localparam logic signed [DATA_W:0]   HALF_X    = (DATA_W+1)'((2 ** FRAC_BITS) / 2);

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    FINAL,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic                          acceptStart;
  logic                          issue;
  logic                          finalize;

  logic [IN_SIZE*DATA_W-1:0]     inData_q;
  logic [1:0]                    actMode_q;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [JW-1:0]                 j_q;
  logic [JW-1:0]                 prevJ_q;
  logic                          prevValid_q;
  logic [NW-1:0]                 neuron_q;
  logic [AW-1:0]                 addr_q;
  logic [OUT_SIZE*DATA_W-1:0]    outData_q, outData_d;

  logic signed [DATA_W-1:0]      xSel;
  logic signed [WEIGHT_W-1:0]    wSigned;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       term;
  logic signed [ACC_W-1:0]       shifted;
  logic signed [DATA_W-1:0]      satR;
  logic signed [DATA_W-1:0]      quarter;
  logic signed [DATA_W:0]        hsSum;
  logic signed [DATA_W-1:0]      actOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (j_q == JW'(STRIDE - 1)) state_d = DRAIN;
      DRAIN:   state_d = FINAL;
      FINAL:   state_d = (neuron_q == NW'(OUT_SIZE - 1)) ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    acceptStart = 1'b0;
    issue       = 1'b0;
    finalize    = 1'b0;
    case (state_q)
      IDLE:  acceptStart = start;
      MAC: begin
        busy  = 1'b1;
        issue = 1'b1;
      end
      DRAIN: busy = 1'b1;
      FINAL: begin
        busy     = 1'b1;
        finalize = 1'b1;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign w_addr   = issue ? addr_q : '0;
  assign out_data = outData_q;

  // Weight data lags its address by one cycle, so the product uses the previous cycle's column index.
  always_comb begin
    xSel = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      if (prevJ_q == JW'(i)) xSel = inData_q[i*DATA_W +: DATA_W];
    end
  end

  assign wSigned = w_rdata;
  assign prod    = PROD_W'(xSel) * PROD_W'(wSigned);

  always_comb begin
    term = ACC_W'(prod);
`ifdef DENSE_ENGINE_BIAS_EN
    if (prevJ_q == JW'(IN_SIZE)) term = ACC_W'(wSigned) <<< FRAC_BITS;
`endif
  end

  always_comb begin
    acc_d = acc_q;
    if (acceptStart || finalize) begin
      acc_d = '0;
    end else if (prevValid_q) begin
      acc_d = acc_q + term;
    end
  end

  assign shifted = acc_q >>> FRAC_BITS;

  always_comb begin
    if (shifted > ACC_W'(D_MAX)) begin
      satR = D_MAX;
    end else if (shifted < ACC_W'(D_MIN)) begin
      satR = D_MIN;
    end else begin
      satR = shifted[DATA_W-1:0];
    end
  end

  assign quarter = satR >>> 2;
  assign hsSum   = (DATA_W+1)'(quarter) + HALF_X;

  // Widened sum keeps the sigmoid offset from wrapping before it is clamped.
  always_comb begin
    case (actMode_q)
      2'd1: actOut = satR[DATA_W-1] ? '0 : satR;
      2'd2: begin
        if (hsSum[DATA_W]) begin
          actOut = '0;
        end else if (hsSum > ONE_X) begin
          actOut = ONE_Q;
        end else begin
          actOut = hsSum[DATA_W-1:0];
        end
      end
      2'd3: begin
        if (satR > ONE_Q) begin
          actOut = ONE_Q;
        end else if (satR < NEG_ONE_Q) begin
          actOut = NEG_ONE_Q;
        end else begin
          actOut = satR;
        end
      end
      default: actOut = satR;
    endcase
  end

  always_comb begin
    outData_d = outData_q;
    for (int o = 0; o < OUT_SIZE; o++) begin
      if (neuron_q == NW'(o)) outData_d[o*DATA_W +: DATA_W] = actOut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inData_q    <= '0;
      actMode_q   <= '0;
      acc_q       <= '0;
      j_q         <= '0;
      prevJ_q     <= '0;
      prevValid_q <= 1'b0;
      neuron_q    <= '0;
      addr_q      <= '0;
      outData_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      prevValid_q <= issue;
      prevJ_q     <= j_q;
      if (acceptStart) begin
        inData_q  <= in_data;
        actMode_q <= act_mode;
        j_q       <= '0;
        neuron_q  <= '0;
        addr_q    <= '0;
      end else begin
        if (issue) begin
          addr_q <= addr_q + AW'(1);
          j_q    <= (j_q == JW'(STRIDE - 1)) ? '0 : j_q + JW'(1);
        end
        if (finalize) begin
          neuron_q  <= neuron_q + NW'(1);
          outData_q <= outData_d;
        end
      end
    end
  end

endmodule

// File: doc/dense_engine.md
DENSE_ENGINE -- requirements
Module: dense_engine

Interface
REQ-001 SHALL have parameter IN_SIZE, default 42: input vector length (≥1).
REQ-002 SHALL have parameter OUT_SIZE, default 24: output neuron count (≥1).
REQ-003 SHALL have parameter DATA_W, default 16: signed width of input and output elements.
REQ-004 SHALL have parameter WEIGHT_W, default 16: signed width of weight and bias words.
REQ-005 SHALL have parameter FRAC_BITS, default 8: fractional bits of the shared Q format (1.0 = 2^FRAC_BITS).
REQ-006 SHALL have port clk, input, 1 bit: sole clock, all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: request one layer evaluation.
REQ-009 SHALL have port act_mode, input, 2 bits: 0 identity, 1 ReLU, 2 hard sigmoid, 3 hard tanh.
REQ-010 SHALL have port in_data, input, IN_SIZE*DATA_W bits: packed feature vector, element i at [i*DATA_W +: DATA_W].
REQ-011 SHALL have port w_addr, output, clog2(OUT_SIZE*STRIDE) bits: weight memory read address.
REQ-012 SHALL have port w_rdata, input, WEIGHT_W bits: weight memory data, valid exactly one cycle after w_addr.
REQ-013 SHALL have port busy, output, 1 bit: high from accepted start until done.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when out_data is complete.
REQ-015 SHALL have port out_data, output, OUT_SIZE*DATA_W bits: packed result vector, neuron o at [o*DATA_W +: DATA_W].

Function
REQ-016 SHALL use FSM states IDLE -> MAC -> DRAIN -> FINAL -> (MAC for the next neuron | DONE) -> IDLE.
REQ-017 SHALL accept start only in IDLE; on acceptance it latches in_data and act_mode, sets busy, and clears the accumulator.
REQ-018 SHALL ignore start while busy, and ignore changes to in_data and act_mode after acceptance.
REQ-019 SHALL, for neuron o, issue addresses o*STRIDE+j for j = 0..STRIDE-1 on consecutive cycles; word j < IN_SIZE multiplies input element j.
REQ-020 SHALL accumulate signed products into an accumulator of DATA_W+WEIGHT_W+clog2(IN_SIZE+1)+1 bits with no intermediate overflow.
REQ-021 SHALL, in FINAL, compute r = acc >>> FRAC_BITS (arithmetic shift, floor rounding).
REQ-022 SHALL, in FINAL, saturate r to the signed DATA_W range.
REQ-023 SHALL, in FINAL, apply the activation selected by act_mode and write the result to the out_data slot for neuron o.
REQ-024 SHALL implement ReLU as max(r,0).
REQ-025 SHALL implement hard sigmoid as clamp((r>>>2) + 2^(FRAC_BITS-1), 0, 2^FRAC_BITS).
REQ-026 SHALL implement hard tanh as clamp(r, -2^FRAC_BITS, 2^FRAC_BITS).
REQ-027 SHALL make each neuron take STRIDE+2 cycles (STRIDE MAC/issue, 1 DRAIN, 1 FINAL).
REQ-028 SHALL assert done exactly OUT_SIZE*(STRIDE+2)+1 cycles after the cycle in which start is sampled high, then return to IDLE.
REQ-029 SHALL drop busy in the same cycle done asserts.
REQ-030 SHALL hold out_data stable from done until the next accepted start.
REQ-031 SHALL allow a start in the cycle after done, which is accepted.
REQ-032 SHALL hold w_addr at 0 whenever in IDLE.

Reset
REQ-033 SHALL, when rst is high at a clock edge, force IDLE and set busy=0, done=0, out_data=0, w_addr=0, and clear the accumulator and neuron counter, including mid-evaluation.
REQ-034 SHALL give rst priority over a simultaneous start, and SHALL NOT accept start in the reset cycle.

Configuration
REQ-035 SHALL, when macro DENSE_ENGINE_BIAS_EN is defined, set STRIDE = IN_SIZE+1; word j=IN_SIZE is neuron o's bias, added in DRAIN as bias<<FRAC_BITS.
REQ-036 SHALL, when DENSE_ENGINE_BIAS_EN is undefined, set STRIDE = IN_SIZE with no bias word or bias logic.

Verification (IN_SIZE=4, OUT_SIZE=2, DATA_W=WEIGHT_W=16, FRAC_BITS=8)
REQ-037 SHALL verify: all inputs 256, all weights 128, no bias, act_mode=0 -> out_data slots both 512, done exactly 2*(4+2)+1=13 cycles after start.
REQ-038 SHALL verify: same data, act_mode=3 -> 256 per slot; act_mode=2 -> 256; weights -128 with act_mode=1 -> 0.
REQ-039 SHALL verify: inputs 32767, weights 32767, act_mode=0 -> 32767 (positive saturation); weights -32768 -> -32768.
REQ-040 SHALL verify: with DENSE_ENGINE_BIAS_EN, inputs 256, weights 128, bias 256, act_mode=0 -> 768 per slot, done at 2*(5+2)+1=15 cycles.
REQ-041 SHALL verify: start pulsed again at cycle 5 of an evaluation -> ignored, single done at cycle 13; rst at cycle 7 -> busy=0, out_data=0 next cycle, no done.
REQ-042 SHALL verify: start in the cycle after done -> accepted, busy=1 next cycle, second result correct.
